// File: rtl/smp_bus_pkg.sv
// smp_bus_pkg: shared FSM state/op types, core-count limit and saturating increment for smp_bus_ctrl
package smp_bus_pkg;
  localparam int MAX_CORES = 8;
  typedef enum logic [2:0] {IDLE, SNOOP, MEM_RD, MEM_WR, RESP} bus_state_t;
  typedef enum logic {OP_RD = 1'b0, OP_WB = 1'b1} bus_op_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/smp_bus_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after last_grant
module rr_arbiter import smp_bus_pkg::*; #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);
  localparam int IW = $clog2(N);
  logic          found;
  logic [IW-1:0] k;
  always_comb begin
    grant = '0;
    grant_idx = '0;
    found = 1'b0;
    k = '0;
    for (int i = 1; i <= N; i++) begin
      k = IW'((int'(last_grant) + i) % N);
      if (!found && req[k]) begin
        found = 1'b1;
        grant_idx = k;
        grant[k] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/smp_bus_ctrl.sv
// smp_bus_ctrl: round-robin snooping shared-bus controller; statistics counters built only with SMP_BUS_STATS_EN
module smp_bus_ctrl import smp_bus_pkg::*; #(
  parameter int NCORES  = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NCORES-1:0]          req_valid,
  input  logic [NCORES-1:0]          req_op,
  input  logic [NCORES-1:0][AW-1:0]  req_addr,
  input  logic [NCORES-1:0][DW-1:0]  req_wdata,
  output logic [NCORES-1:0]          req_ready,
  output logic [NCORES-1:0]          resp_valid,
  output logic [DW-1:0]              resp_data,
  output logic                       snoop_valid,
  output logic [AW-1:0]              snoop_addr,
  output logic [NCORES-1:0]          snoop_src,
  input  logic [NCORES-1:0]          snoop_hit,
  input  logic [NCORES-1:0][DW-1:0]  snoop_data,
  output logic                       mem_rd,
  output logic                       mem_wr,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  input  logic [DW-1:0]              mem_rdata,
  output logic [31:0]                stat_c2c,
  output logic [31:0]                stat_memrd,
  output logic [31:0]                stat_wb
);
  localparam int IW = $clog2(NCORES);
  localparam int CW = $clog2(MEM_LAT + 1);
  bus_state_t        state, state_n;
  logic [AW-1:0]     lat_addr;
  logic [DW-1:0]     lat_wdata, data_r;
  logic [IW-1:0]     last_grant, lat_idx, grant_idx, hit_idx;
  logic [NCORES-1:0] grant, src, hit_mask;
  logic [CW-1:0]     cnt;
  logic              start;
  rr_arbiter #(.N(NCORES)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );
  assign src      = NCORES'(1) << lat_idx;
  assign hit_mask = snoop_hit & ~src;
  assign start    = state == IDLE && |req_valid;
  always_comb begin
    hit_idx = '0;
    for (int i = NCORES - 1; i >= 0; i--) hit_idx = hit_mask[i] ? IW'(i) : hit_idx;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !start ? IDLE : (req_op[grant_idx] == OP_WB) ? MEM_WR : SNOOP;
      SNOOP:   state_n = |hit_mask ? RESP : MEM_RD;
      MEM_RD:  state_n = (cnt == '0) ? RESP : MEM_RD;
      MEM_WR:  state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IW'(NCORES - 1);
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_idx    <= '0;
      data_r     <= '0;
      cnt        <= '0;
    end else begin
      if (start) begin
        last_grant <= grant_idx;
        lat_idx    <= grant_idx;
        lat_addr   <= req_addr[grant_idx];
        lat_wdata  <= req_wdata[grant_idx];
      end
      if (state == SNOOP) begin
        data_r <= snoop_data[hit_idx];
        cnt    <= CW'(MEM_LAT - 1);
      end
      if (state == MEM_RD) begin
        cnt <= cnt - CW'(1);
        if (cnt == '0) data_r <= mem_rdata;
      end
    end
  end
  always_comb begin
    req_ready   = (state == IDLE && !reset) ? grant : '0;
    resp_valid  = (state == RESP && !reset) ? src : '0;
    resp_data   = data_r;
    snoop_valid = state == SNOOP && !reset;
    snoop_addr  = snoop_valid ? lat_addr : '0;
    snoop_src   = snoop_valid ? src : '0;
    mem_rd      = state == MEM_RD && !reset;
    mem_wr      = state == MEM_WR && !reset;
    mem_addr    = (mem_rd || mem_wr) ? lat_addr : '0;
    mem_wdata   = mem_wr ? lat_wdata : '0;
  end
`ifdef SMP_BUS_STATS_EN
  logic is_wb, is_hit;
  always_ff @(posedge clk) begin
    if (reset) begin
      is_wb      <= 1'b0;
      is_hit     <= 1'b0;
      stat_c2c   <= '0;
      stat_memrd <= '0;
      stat_wb    <= '0;
    end else begin
      if (start) is_wb <= req_op[grant_idx] == OP_WB;
      if (state == SNOOP) is_hit <= |hit_mask;
      if (state == RESP) begin
        if (is_wb) stat_wb <= sat_inc(stat_wb);
        else if (is_hit) stat_c2c <= sat_inc(stat_c2c);
        else stat_memrd <= sat_inc(stat_memrd);
      end
    end
  end
`else
  assign stat_c2c   = '0;
  assign stat_memrd = '0;
  assign stat_wb    = '0;
`endif
endmodule

// File: tb/tb_smp_bus_ctrl.sv
// tb_smp_bus_ctrl: randomized self-checking bench for smp_bus_ctrl against a transaction-level model
module tb_smp_bus_ctrl;
  localparam int N = 4, AW = 32, DW = 32, LAT = 2;
`ifdef SMP_BUS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         req_valid, req_op, req_ready, resp_valid, snoop_src, snoop_hit;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata, snoop_data;
  logic [DW-1:0]        resp_data, mem_wdata, mem_rdata;
  logic [AW-1:0]        snoop_addr, mem_addr;
  logic                 snoop_valid, mem_rd, mem_wr;
  logic [31:0]          stat_c2c, stat_memrd, stat_wb;

  smp_bus_ctrl #(.NCORES(N), .AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_src(snoop_src), .snoop_hit(snoop_hit),
    .snoop_data(snoop_data), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stat_c2c(stat_c2c), .stat_memrd(stat_memrd),
    .stat_wb(stat_wb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int m_c2c = 0, m_memrd = 0, m_wb = 0, m_last = N - 1;
  int o_ready_n, o_grant_cyc, o_snoop_cyc, o_rd_first, o_rd_n, o_wr_first, o_wr_n, o_resp_cyc;
  logic [N-1:0]  o_grant, o_src, o_resp;
  logic [31:0]   o_snoop_addr, o_mem_addr, o_mem_wdata, o_resp_data;
  logic [31:0]   rd_at [0:15];

  function automatic int lowest_other(input int core, input logic [N-1:0] hit);
    for (int i = 0; i < N; i++) if (hit[i] && i != core) return i;
    return -1;
  endfunction

  function automatic int latency(input int core, input bit op, input logic [N-1:0] hit);
    if (op) return 2;
    return (lowest_other(core, hit) >= 0) ? 2 : LAT + 2;
  endfunction

  task automatic model_txn(input int core, input bit op, input logic [N-1:0] hit);
    m_last = core;
    if (op) m_wb++;
    else if (lowest_other(core, hit) >= 0) m_c2c++;
    else m_memrd++;
  endtask

  task automatic do_txn(input int core, input bit op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [N-1:0] hit, input logic [N-1:0][31:0] sdata,
                        input bit fixed, input logic [31:0] fval);
    req_op[core] = op; req_addr[core] = addr; req_wdata[core] = wdata;
    snoop_hit = hit; snoop_data = sdata;
    o_ready_n = 0; o_grant_cyc = -1; o_snoop_cyc = -1; o_rd_first = -1; o_rd_n = 0;
    o_wr_first = -1; o_wr_n = 0; o_resp_cyc = -1; o_grant = '0; o_src = '0; o_resp = '0;
    o_snoop_addr = '0; o_mem_addr = '0; o_mem_wdata = '0; o_resp_data = '0;
    model_txn(core, op, hit);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      req_valid = (o_ready_n == 0) ? N'(1 << core) : '0;
      mem_rdata = fixed ? fval : $urandom;
      rd_at[c] = mem_rdata;
      #1;
      if (req_ready !== '0) begin o_ready_n++; o_grant = req_ready; if (o_grant_cyc < 0) o_grant_cyc = c; end
      if (snoop_valid) begin o_snoop_cyc = c; o_src = snoop_src; o_snoop_addr = snoop_addr; end
      if (mem_rd) begin if (o_rd_first < 0) o_rd_first = c; o_rd_n++; o_mem_addr = mem_addr; end
      if (mem_wr) begin if (o_wr_first < 0) o_wr_first = c; o_wr_n++; o_mem_addr = mem_addr; o_mem_wdata = mem_wdata; end
      if (resp_valid !== '0) begin o_resp_cyc = c; o_resp = resp_valid; o_resp_data = resp_data; break; end
    end
    req_valid = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = '1; req_op = '0; snoop_hit = '1; mem_rdata = $urandom;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    n_cmp++; if ({resp_valid, snoop_valid, mem_rd, mem_wr} !== '0) begin n_bad++; $display("FAIL reset_outputs: got %b want 0", {resp_valid, snoop_valid, mem_rd, mem_wr}); end
    n_cmp++; if ({stat_c2c, stat_memrd, stat_wb} !== 96'd0) begin n_bad++; $display("FAIL reset_stats: got %0h/%0h/%0h want 0", stat_c2c, stat_memrd, stat_wb); end
    @(negedge clk);
    reset = 1'b0; req_valid = '0; snoop_hit = '0;
    m_c2c = 0; m_memrd = 0; m_wb = 0; m_last = N - 1;
    #1;
    n_cmp++; if ({req_ready, mem_addr, snoop_addr} !== '0) begin n_bad++; $display("FAIL idle_outputs: got %0h want 0", {req_ready, mem_addr, snoop_addr}); end
  endtask

  task automatic test_read_miss;
    logic [N-1:0][31:0] sd;
    for (int i = 0; i < N; i++) sd[i] = $urandom;
    do_txn(1, 1'b0, 32'h40, 32'h0, '0, sd, 1'b1, 32'hDEADBEEF);
    n_cmp++; if (o_grant !== 4'b0010 || o_grant_cyc != 0 || o_ready_n != 1) begin n_bad++; $display("FAIL miss_grant: got %b@%0d x%0d want 0010@0 x1", o_grant, o_grant_cyc, o_ready_n); end
    n_cmp++; if (o_snoop_cyc != 1 || o_src !== 4'b0010 || o_snoop_addr !== 32'h40) begin n_bad++; $display("FAIL miss_snoop: got %0d/%b/%0h want 1/0010/40", o_snoop_cyc, o_src, o_snoop_addr); end
    n_cmp++; if (o_rd_first != 2 || o_rd_n != LAT || o_mem_addr !== 32'h40) begin n_bad++; $display("FAIL miss_memrd: got first %0d n %0d addr %0h want 2 %0d 40", o_rd_first, o_rd_n, o_mem_addr, LAT); end
    n_cmp++; if (o_resp_cyc != LAT + 2 || o_resp !== 4'b0010) begin n_bad++; $display("FAIL miss_resp: got %b@%0d want 0010@%0d", o_resp, o_resp_cyc, LAT + 2); end
    n_cmp++; if (o_resp_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL miss_data: got %0h want deadbeef", o_resp_data); end
    @(negedge clk); #1;
    n_cmp++; if (stat_memrd !== (STATS ? 32'(m_memrd) : 32'd0)) begin n_bad++; $display("FAIL miss_stat: got %0d want %0d", stat_memrd, STATS ? m_memrd : 0); end
  endtask

  task automatic test_own_hit;
    logic [N-1:0][31:0] sd;
    for (int i = 0; i < N; i++) sd[i] = $urandom;
    do_txn(2, 1'b0, $urandom, 32'h0, 4'b0100, sd, 1'b0, 32'h0);
    n_cmp++; if (o_rd_n != LAT || o_resp_cyc != LAT + 2 || o_resp !== 4'b0100) begin n_bad++; $display("FAIL own_hit_path: got rd %0d resp %b@%0d want %0d 0100@%0d", o_rd_n, o_resp, o_resp_cyc, LAT, LAT + 2); end
    n_cmp++; if (o_resp_data !== rd_at[LAT + 1]) begin n_bad++; $display("FAIL own_hit_data: got %0h want %0h", o_resp_data, rd_at[LAT + 1]); end
  endtask

  task automatic test_read_hit;
    logic [N-1:0][31:0] sd;
    logic [N-1:0]       hit;
    int core, lo;
    sd = '0; sd[2] = 32'h11; sd[3] = 32'h22;
    do_txn(0, 1'b0, 32'h80, 32'h0, 4'b1100, sd, 1'b0, 32'h0);
    n_cmp++; if (o_src !== 4'b0001 || o_snoop_addr !== 32'h80) begin n_bad++; $display("FAIL hit_snoop: got %b/%0h want 0001/80", o_src, o_snoop_addr); end
    n_cmp++; if (o_resp_cyc != 2 || o_resp !== 4'b0001 || o_resp_data !== 32'h11) begin n_bad++; $display("FAIL hit_resp: got %b@%0d %0h want 0001@2 11", o_resp, o_resp_cyc, o_resp_data); end
    n_cmp++; if (o_rd_n != 0) begin n_bad++; $display("FAIL hit_nomem: got %0d mem_rd cycles want 0", o_rd_n); end
    @(negedge clk); #1;
    n_cmp++; if (stat_c2c !== (STATS ? 32'(m_c2c) : 32'd0)) begin n_bad++; $display("FAIL hit_stat: got %0d want %0d", stat_c2c, STATS ? m_c2c : 0); end
    for (int k = 0; k < 8; k++) begin
      core = $urandom_range(0, N - 1);
      hit = N'($urandom);
      for (int i = 0; i < N; i++) sd[i] = $urandom;
      do_txn(core, 1'b0, $urandom, 32'h0, hit, sd, 1'b0, 32'h0);
      lo = lowest_other(core, hit);
      n_cmp++; if (o_resp_cyc != latency(core, 1'b0, hit) || o_resp !== N'(1 << core)) begin n_bad++; $display("FAIL rand_rd_resp: core %0d hit %b got %b@%0d want @%0d", core, hit, o_resp, o_resp_cyc, latency(core, 1'b0, hit)); end
      n_cmp++; if (o_resp_data !== ((lo >= 0) ? sd[lo] : rd_at[LAT + 1])) begin n_bad++; $display("FAIL rand_rd_data: core %0d hit %b got %0h want %0h", core, hit, o_resp_data, (lo >= 0) ? sd[lo] : rd_at[LAT + 1]); end
    end
  endtask

  task automatic test_writeback;
    logic [N-1:0][31:0] sd;
    for (int i = 0; i < N; i++) sd[i] = $urandom;
    do_txn(3, 1'b1, 32'h100, 32'hCAFE, '1, sd, 1'b0, 32'h0);
    n_cmp++; if (o_wr_first != 1 || o_wr_n != 1 || o_mem_addr !== 32'h100 || o_mem_wdata !== 32'hCAFE) begin n_bad++; $display("FAIL wb_mem: got %0d x%0d %0h/%0h want 1 x1 100/cafe", o_wr_first, o_wr_n, o_mem_addr, o_mem_wdata); end
    n_cmp++; if (o_snoop_cyc != -1 || o_rd_n != 0) begin n_bad++; $display("FAIL wb_nosnoop: got snoop@%0d rd %0d want none", o_snoop_cyc, o_rd_n); end
    n_cmp++; if (o_resp_cyc != 2 || o_resp !== 4'b1000) begin n_bad++; $display("FAIL wb_resp: got %b@%0d want 1000@2", o_resp, o_resp_cyc); end
    @(negedge clk); #1;
    n_cmp++; if (stat_wb !== (STATS ? 32'(m_wb) : 32'd0)) begin n_bad++; $display("FAIL wb_stat: got %0d want %0d", stat_wb, STATS ? m_wb : 0); end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] pend;
    int wait_n [N];
    int grants, exp_resp_cyc, exp_core, g, worst;
    bit busy;
    pend = '0; grants = 0; exp_resp_cyc = -1; exp_core = 0; busy = 1'b0;
    for (int i = 0; i < N; i++) wait_n[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (!pend[i] && grants < 60 && (grants < 16 || $urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1; req_op[i] = 1'($urandom); req_addr[i] = $urandom; req_wdata[i] = $urandom;
        end
      req_valid = pend;
      mem_rdata = $urandom;
      #1;
      if (req_ready !== '0) begin
        g = -1;
        for (int k = 1; k <= N; k++) if (g < 0 && pend[(m_last + k) % N]) g = (m_last + k) % N;
        n_cmp++;
        if (g < 0 || busy || req_ready !== N'(1 << g)) begin
          n_bad++; $display("FAIL rr_grant: got %b want core %0d (busy %0d)", req_ready, g, busy);
          continue;
        end
        worst = 0;
        for (int i = 0; i < N; i++) if (pend[i] && i != g) begin wait_n[i]++; if (wait_n[i] > worst) worst = wait_n[i]; end
        n_cmp++; if (worst > N - 1) begin n_bad++; $display("FAIL rr_starve: got wait %0d want <= %0d", worst, N - 1); end
        wait_n[g] = 0; pend[g] = 1'b0;
        snoop_hit = N'($urandom);
        for (int i = 0; i < N; i++) snoop_data[i] = $urandom;
        exp_resp_cyc = c + latency(g, req_op[g], snoop_hit);
        exp_core = g; busy = 1'b1;
        model_txn(g, req_op[g], snoop_hit);
        grants++;
      end
      if (resp_valid !== '0) begin
        n_cmp++; if (!busy || c != exp_resp_cyc || resp_valid !== N'(1 << exp_core)) begin n_bad++; $display("FAIL rr_resp: got %b@%0d want %b@%0d", resp_valid, c, N'(1 << exp_core), exp_resp_cyc); end
        busy = 1'b0;
      end else if (busy && c > exp_resp_cyc) begin
        n_cmp++; n_bad++; $display("FAIL rr_resp_timeout: got none want %b@%0d", N'(1 << exp_core), exp_resp_cyc);
        busy = 1'b0;
      end
      if (grants >= 60 && !busy && pend == '0) break;
    end
    req_valid = '0;
    n_cmp++; if (grants < 60) begin n_bad++; $display("FAIL rr_count: got %0d grants want 60", grants); end
    @(negedge clk); #1;
    n_cmp++; if ({stat_c2c, stat_memrd, stat_wb} !== (STATS ? {32'(m_c2c), 32'(m_memrd), 32'(m_wb)} : 96'd0)) begin n_bad++; $display("FAIL rr_stats: got %0d/%0d/%0d want %0d/%0d/%0d", stat_c2c, stat_memrd, stat_wb, m_c2c, m_memrd, m_wb); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    snoop_hit = '0; req_op = '0; req_addr[1] = 32'h200;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_valid = (c == 0) ? 4'b0010 : '0;
      reset = (c == 3);
      #1;
      if (c == 2) begin n_cmp++; if (mem_rd !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre: got mem_rd %b want 1", mem_rd); end end
    end
    @(negedge clk);
    reset = 1'b0;
    m_c2c = 0; m_memrd = 0; m_wb = 0; m_last = N - 1;
    #1;
    n_cmp++; if ({mem_rd, mem_wr, snoop_valid, resp_valid} !== '0) begin n_bad++; $display("FAIL rst_mid_post: got %b want 0", {mem_rd, mem_wr, snoop_valid, resp_valid}); end
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin @(negedge clk); #1; if (resp_valid !== '0) seen = 1'b1; end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL rst_mid_noresp: got resp_valid want none"); end
    @(negedge clk);
    req_valid = '1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rst_mid_first: got %b want 0001", req_ready); end
    model_txn(0, 1'b0, snoop_hit);
    seen = 1'b0;
    for (int c = 1; c < 12 && !seen; c++) begin
      @(negedge clk); req_valid = '0; #1;
      if (resp_valid !== '0) begin
        seen = 1'b1;
        n_cmp++; if (resp_valid !== 4'b0001 || c != LAT + 2) begin n_bad++; $display("FAIL rst_mid_resp: got %b@%0d want 0001@%0d", resp_valid, c, LAT + 2); end
      end
    end
    if (!seen) begin n_cmp++; n_bad++; $display("FAIL rst_mid_timeout: got no resp want 0001"); end
    @(negedge clk); #1;
    n_cmp++; if ({stat_c2c, stat_memrd, stat_wb} !== (STATS ? {32'(m_c2c), 32'(m_memrd), 32'(m_wb)} : 96'd0)) begin n_bad++; $display("FAIL rst_mid_stats: got %0d/%0d/%0d want %0d/%0d/%0d", stat_c2c, stat_memrd, stat_wb, m_c2c, m_memrd, m_wb); end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_op = '0; req_addr = '0; req_wdata = '0;
    snoop_hit = '0; snoop_data = '0; mem_rdata = '0;
    test_reset;
    test_read_miss;
    test_own_hit;
    test_read_hit;
    test_writeback;
    test_round_robin;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/smp_bus_ctrl.md
# smp_bus_ctrl

Parametrised shared-bus controller for the N-core SMP cluster. It arbitrates bus requests from NCORES private data caches with round-robin priority. Each read is broadcast as a snoop to every other cache and is served cache-to-cache on a hit, or from main memory on a miss. Write-backs are serialised onto a single memory write port, replacing the per-cache write ports of the two-core generation.

## Interface
- NCORES, 2, number of caches/cores (2..8)
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 2, memory read latency in cycles (≥1)

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NCORES  per-cache bus request
- req_op  in  NCORES  per-cache op: 0 = read, 1 = write-back
- req_addr  in  NCORES×AW  per-cache address, packed [NCORES-1:0][AW-1:0]
- req_wdata  in  NCORES×DW  per-cache write-back data
- req_ready  out  NCORES  one-hot grant pulse; request accepted this cycle
- resp_valid  out  NCORES  one-hot completion pulse
- resp_data  out  DW  read data, valid with resp_valid (don't-care for write-back)
- snoop_valid  out  1  snoop broadcast strobe
- snoop_addr  out  AW  snooped address
- snoop_src  out  NCORES  one-hot requester; that cache ignores the snoop
- snoop_hit  in  NCORES  per-cache hit response, same cycle as snoop_valid
- snoop_data  in  NCORES×DW  per-cache supplied data
- mem_rd  out  1  memory read enable
- mem_wr  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- stat_c2c, stat_memrd, stat_wb  out  32 each  statistics counters (see Configuration)

## Operation
- FSM states: IDLE, SNOOP, MEM_RD, MEM_WR, RESP.
- IDLE: if any req_valid, grant the first requester at or after (last_grant+1) mod NCORES. Pulse req_ready for the granted cache, latch op/addr/wdata/index, and update last_grant.
  - Read → SNOOP.
  - Write-back → MEM_WR.
  - No request → stay in IDLE.
- Requesters hold req_valid and their payload stable until req_ready. Deasserting before grant is allowed; the request is then simply not seen.
- SNOOP: snoop_valid=1, snoop_addr=latched addr, snoop_src=one-hot requester.
  - snoop_hit is masked by ~snoop_src.
  - Any masked hit: capture snoop_data of the lowest-index hitter, then → RESP.
  - No hit: → MEM_RD.
- MEM_RD: mem_rd=1 and mem_addr held for MEM_LAT cycles via a down-counter. mem_rdata is captured in the final cycle, then → RESP.
- MEM_WR: mem_wr=1, mem_addr/mem_wdata from latch, for one cycle, then → RESP.
- RESP: resp_valid pulses for the latched requester, with resp_data = captured data. → IDLE.
- One transaction in flight at a time; a new grant can occur in the IDLE cycle following RESP.

## Timing
- Reset: state=IDLE, last_grant=NCORES-1 (core 0 wins first), all outputs 0, counters 0.
- Read with snoop hit: grant in cycle 0, snoop in cycle 1, resp in cycle 2.
- Read with miss: grant 0, snoop 1, mem_rd high in cycles 2..MEM_LAT+1, resp in MEM_LAT+2.
- Write-back: grant 0, mem_wr 1, resp 2.
- Simultaneous requests: exactly one req_ready per grant. Round-robin ensures no cache waits more than NCORES-1 transactions.
- Multiple snoop hits: lowest index supplies data; the others are ignored.
- A requester's own snoop_hit is ignored even if asserted.
- Reset mid-transaction: return to IDLE next cycle. The transaction is dropped with no resp_valid, and any in-progress mem_rd/mem_wr deasserts.

## Configuration
- SMP_BUS_STATS_EN defined:
  - stat_c2c counts snoop-hit reads.
  - stat_memrd counts memory reads.
  - stat_wb counts write-backs.
  - Each increments once per transaction in its RESP cycle, saturates at 2^32-1, and clears on reset.
- Not defined: the ports remain and are tied to 0, and no counter logic is built.

## Structure
- Package smp_bus_pkg:
  - bus_state_t enum (IDLE, SNOOP, MEM_RD, MEM_WR, RESP)
  - bus_op_t (OP_RD=0, OP_WB=1)
  - MAX_CORES=8
- Sub-module rr_arbiter: parameter N; inputs req and last_grant; outputs one-hot grant and grant index. Purely combinational. The pointer register lives in smp_bus_ctrl.

## Test plan
- NCORES=4, MEM_LAT=2, core 1 reads 0x40, no snoop hits, mem_rdata=0xDEADBEEF → mem_rd in cycles 2–3; resp_valid=4'b0010 in cycle 4 with data 0xDEADBEEF; stat_memrd=1.
- Core 0 reads 0x80, cache 2 and cache 3 hit with data 0x11/0x22 → snoop_src=4'b0001; resp in cycle 2 with 0x11; mem_rd never asserted; stat_c2c=1.
- Core 2 reads with only its own snoop_hit high → treated as miss; goes to memory.
- All four cores assert req_valid continuously (mix of reads and write-backs) → grant order 0,1,2,3,0…; no core starved.
- Core 3 write-back addr 0x100, data 0xCAFE → mem_wr one cycle in cycle 1 with that addr/data; resp_valid=4'b1000 in cycle 2; stat_wb=1.
- Reset asserted in the second MEM_RD cycle → next cycle IDLE, mem_rd=0, no resp_valid; after release, core 0 is granted first.
